// File: rtl/bus_uart_pkg.sv
`default_nettype none
// ============================================================================
// bus_uart_pkg: register map, STATUS layout and TX FSM states for bus_uart_tx.
// Revision: 1.0
// ============================================================================
package bus_uart_pkg;

  localparam logic [1:0] c_REG_TXDATA   = 2'd0;
  localparam logic [1:0] c_REG_STATUS   = 2'd1;
  localparam logic [1:0] c_REG_BAUD_DIV = 2'd2;

  localparam int c_STATUS_BUSY      = 0;
  localparam int c_STATUS_FULL      = 1;
  localparam int c_STATUS_EMPTY     = 2;
  localparam int c_STATUS_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo: single-clock FIFO with occupancy count; overflow/underflow ignored.
// Revision: 1.0
// ============================================================================
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int                 c_PTR_W = $clog2(Depth);
  localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(Depth);

  logic [Width-1:0]   mem_q [Depth];
  logic [c_PTR_W-1:0] wptr_q;
  logic [c_PTR_W-1:0] rptr_q;
  logic [c_PTR_W:0]   count_q;
  logic               w_push;
  logic               w_pop;

  assign full_o  = (count_q == c_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // Pointers are exactly log2(Depth) bits, so they wrap without compare logic.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + 1'b1;
      if (w_pop)  rptr_q <= rptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_uart_tx.sv
`default_nettype none
// ============================================================================
// bus_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and baud FSM.
// Revision: 1.0
// ============================================================================
module bus_uart_tx
  import bus_uart_pkg::*;
#(
  parameter int AddrWidth  = 32,
  parameter int DataWidth  = 32,
  parameter int FifoDepth  = 8,
  parameter int DefaultDiv = 868
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 re_i,
  input  logic                 we_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 gnt_o,
  output logic                 tx_o
);

  localparam int c_CNT_W = $clog2(FifoDepth) + 1;

  logic                 w_full;
  logic                 w_empty;
  logic [c_CNT_W-1:0]   w_count;
  logic [7:0]           w_head;
  logic [1:0]           w_reg;
  logic                 w_req;
  logic                 w_wr_stall;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_baud_wr;
  logic                 w_pop;
  logic                 w_load;
  logic                 w_bit_end;
  logic [DataWidth-1:0] w_rd_val;
  logic                 w_unused;

  logic                 gnt_q;
  logic [DataWidth-1:0] rdata_q;
  logic [15:0]          baud_q;

  tx_state_e            state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bit_q, bit_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          div_q, div_d;
  logic                 tx_q, tx_d;

  assign w_unused = ^{addr_i[AddrWidth-1:4], addr_i[1:0], wdata_i[DataWidth-1:16]};

  sync_fifo #(
    .Width (8),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (wdata_i[7:0]),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // A read wins when both strobes are high; a TXDATA write into a full FIFO waits.
  assign w_reg      = addr_i[3:2];
  assign w_req      = (re_i | we_i) & ~gnt_q;
  assign w_wr_stall = ~re_i & we_i & (w_reg == c_REG_TXDATA) & w_full;
  assign w_accept   = w_req & ~w_wr_stall;
  assign w_push     = w_accept & ~re_i & (w_reg == c_REG_TXDATA);
  assign w_baud_wr  = w_accept & ~re_i & (w_reg == c_REG_BAUD_DIV);

  always_comb begin
    w_rd_val = '0;
    case (w_reg)
      c_REG_STATUS: begin
        w_rd_val[c_STATUS_BUSY]                     = (state_q != TX_IDLE);
        w_rd_val[c_STATUS_FULL]                     = w_full;
        w_rd_val[c_STATUS_EMPTY]                    = w_empty;
        w_rd_val[c_STATUS_COUNT_LSB +: c_CNT_W]     = w_count;
      end
      c_REG_BAUD_DIV: w_rd_val[15:0] = baud_q;
      default:        w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      gnt_q   <= 1'b0;
      rdata_q <= '0;
      baud_q  <= 16'(DefaultDiv);
    end else begin
      gnt_q   <= w_accept;
      rdata_q <= (w_accept & re_i) ? w_rd_val : '0;
      if (w_baud_wr) begin
        baud_q <= (wdata_i[15:0] == 16'd0) ? 16'd1 : wdata_i[15:0];
      end
    end
  end

  assign w_bit_end = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    w_load  = 1'b0;
    w_pop   = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      TX_IDLE: begin
        w_load = ~w_empty;
      end
      TX_START: begin
        if (w_bit_end) begin
          state_d = TX_DATA;
          bit_d   = 3'd0;
          cnt_d   = div_q - 16'd1;
        end else begin
          cnt_d   = cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (w_bit_end) begin
          cnt_d = div_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (w_bit_end) begin
          w_load = ~w_empty;
          if (w_empty) state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
    endcase

    // The divider is sampled only at frame start so mid-frame writes wait a frame.
    if (w_load) begin
      w_pop   = 1'b1;
      state_d = TX_START;
      shift_d = w_head;
      div_d   = baud_q;
      cnt_d   = baud_q - 16'd1;
    end

    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= TX_IDLE;
      shift_q <= 8'd0;
      bit_q   <= 3'd0;
      cnt_q   <= 16'd0;
      div_q   <= 16'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign rdata_o = rdata_q;
  assign tx_o    = tx_q;

endmodule
`default_nettype wire
